fila_registradores: RTL and testbench

FILA_REGISTRADORES -- requirements
Module: fila_registradores

---
 rtl/fila_registradores.sv | 87 ++++++++
 tb/tb_fila_registradores.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fila_registradores.sv
// Synchronous first-word-fall-through FIFO with occupancy count and full/empty flags.
// Define FILA_REGISTRADORES_ERRO_EN to add sticky erro_overflow / erro_underflow outputs.
module fila_registradores #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         D,
    output logic [WIDTH-1:0]         Q,
    output logic                     vazio,
    output logic                     cheio,
`ifdef FILA_REGISTRADORES_ERRO_EN
    output logic                     erro_overflow,
    output logic                     erro_underflow,
`endif
    output logic [$clog2(DEPTH):0]   contagem
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    assign vazio    = (count == '0);
    assign cheio    = (count == FULL_COUNT);
    assign contagem = count;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = enable & pop & ~vazio;
    assign push_ok = enable & push & (~cheio | pop_ok);

    // Stale storage stays hidden behind the empty flag.
    assign Q = vazio ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= D;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FILA_REGISTRADORES_ERRO_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            erro_overflow  <= 1'b0;
            erro_underflow <= 1'b0;
        end else begin
            if (enable && push && cheio && !pop_ok) begin
                erro_overflow <= 1'b1;
            end
            if (enable && pop && vazio) begin
                erro_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fila_registradores.sv
// Randomized and directed bench for fila_registradores, checked against a queue-based model.
module tb_fila_registradores;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clock;
    logic              clear;
    logic              enable;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q;
    logic              vazio;
    logic              cheio;
    logic [$clog2(DEPTH):0] contagem;
`ifdef FILA_REGISTRADORES_ERRO_EN
    logic              erro_overflow;
    logic              erro_underflow;
`endif

    int compared;
    int mismatched;
    bit checking;

    logic [WIDTH-1:0] model_q [$];
    bit model_ovf;
    bit model_udf;

    fila_registradores #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .clear          (clear),
        .enable         (enable),
        .push           (push),
        .pop            (pop),
        .D              (D),
        .Q              (Q),
        .vazio          (vazio),
        .cheio          (cheio),
`ifdef FILA_REGISTRADORES_ERRO_EN
        .erro_overflow  (erro_overflow),
        .erro_underflow (erro_underflow),
`endif
        .contagem       (contagem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a plain queue updated from the inputs seen at each rising edge.
    always @(posedge clock) begin
        int size;
        bit pop_ok;
        bit push_ok;
        size = model_q.size();
        if (clear) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
        end else if (enable) begin
            pop_ok  = pop && (size > 0);
            push_ok = push && ((size < DEPTH) || pop_ok);
            if (push && !push_ok) model_ovf = 1'b1;
            if (pop && size == 0) model_udf = 1'b1;
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(D);
        end
    end

    always @(negedge clock) begin
        int size;
        logic [WIDTH-1:0] exp_q;
        if (checking) begin
            size  = model_q.size();
            exp_q = (size > 0) ? model_q[0] : '0;
            compared += 4;
            if (contagem !== size[$clog2(DEPTH):0]) begin
                mismatched++;
                $display("[TB] FAIL model_contagem t=%0t got %0d expected %0d", $time, contagem, size);
            end
            if (vazio !== (size == 0)) begin
                mismatched++;
                $display("[TB] FAIL model_vazio t=%0t got %0b expected %0b", $time, vazio, size == 0);
            end
            if (cheio !== (size == DEPTH)) begin
                mismatched++;
                $display("[TB] FAIL model_cheio t=%0t got %0b expected %0b", $time, cheio, size == DEPTH);
            end
            if (Q !== exp_q) begin
                mismatched++;
                $display("[TB] FAIL model_Q t=%0t got %h expected %h", $time, Q, exp_q);
            end
`ifdef FILA_REGISTRADORES_ERRO_EN
            compared += 2;
            if (erro_overflow !== model_ovf) begin
                mismatched++;
                $display("[TB] FAIL model_ovf t=%0t got %0b expected %0b", $time, erro_overflow, model_ovf);
            end
            if (erro_underflow !== model_udf) begin
                mismatched++;
                $display("[TB] FAIL model_udf t=%0t got %0b expected %0b", $time, erro_underflow, model_udf);
            end
`endif
        end
    end

    task automatic applyStimulus(input bit c, input bit en, input bit ps, input bit pp,
                                 input logic [WIDTH-1:0] d);
        clear  = c;
        enable = en;
        push   = ps;
        pop    = pp;
        D      = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] vals [4];
        logic [WIDTH-1:0] held_q;
        logic [31:0]      held_cnt;

        compared   = 0;
        mismatched = 0;
        checking   = 1'b0;
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(1, 1, 1, 1, 16'hFFFF);
        checking = 1'b1;

        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("reset_vazio", 32'(vazio), 32'd1);
        checkOutput("reset_cheio", 32'(cheio), 32'd0);
        checkOutput("reset_contagem", 32'(contagem), 32'd0);
        checkOutput("reset_Q", 32'(Q), 32'd0);

        applyStimulus(0, 1, 1, 0, 16'h000A);
        checkOutput("first_push_Q", 32'(Q), 32'h000A);
        applyStimulus(0, 1, 1, 0, 16'h000B);
        applyStimulus(0, 1, 1, 0, 16'h000C);
        applyStimulus(0, 1, 1, 0, 16'h000D);
        checkOutput("full_cheio", 32'(cheio), 32'd1);
        checkOutput("full_contagem", 32'(contagem), 32'd4);
        applyStimulus(0, 1, 1, 0, 16'h000E);
        checkOutput("drop_contagem", 32'(contagem), 32'd4);
        checkOutput("drop_Q", 32'(Q), 32'h000A);
`ifdef FILA_REGISTRADORES_ERRO_EN
        checkOutput("drop_erro_overflow", 32'(erro_overflow), 32'd1);
`endif
        vals = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        for (int i = 0; i < 4; i++) begin
            checkOutput("pop_order_Q", 32'(Q), 32'(vals[i]));
            applyStimulus(0, 1, 0, 1, '0);
        end
        checkOutput("drained_vazio", 32'(vazio), 32'd1);
        checkOutput("drained_Q", 32'(Q), 32'd0);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 16'h0021 + 16'(i));
        applyStimulus(0, 1, 1, 1, 16'h0011);
        checkOutput("full_pushpop_contagem", 32'(contagem), 32'd4);
        checkOutput("full_pushpop_Q", 32'(Q), 32'h0022);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, '0);
        checkOutput("full_pushpop_last_Q", 32'(Q), 32'h0011);
        applyStimulus(0, 1, 0, 1, '0);

        applyStimulus(0, 1, 0, 1, '0);
        checkOutput("pop_empty_contagem", 32'(contagem), 32'd0);
        applyStimulus(0, 1, 1, 1, 16'h1234);
        checkOutput("pushpop_empty_contagem", 32'(contagem), 32'd1);
        checkOutput("pushpop_empty_Q", 32'(Q), 32'h1234);
`ifdef FILA_REGISTRADORES_ERRO_EN
        checkOutput("pushpop_empty_underflow", 32'(erro_underflow), 32'd1);
`endif
        applyStimulus(1, 0, 0, 0, '0);

        // Ten push/pop pairs walk both pointers around DEPTH=4 twice.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, 0, 16'h0100 + 16'(i));
            checkOutput("wrap_Q", 32'(Q), 32'(16'h0100 + 16'(i)));
            applyStimulus(0, 1, 0, 1, '0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 16'h0200 + 16'(i));
        checkOutput("pre_clear_contagem", 32'(contagem), 32'd3);
        applyStimulus(1, 1, 1, 1, 16'h0BAD);
        checkOutput("mid_clear_contagem", 32'(contagem), 32'd0);
        checkOutput("mid_clear_Q", 32'(Q), 32'd0);
        applyStimulus(0, 1, 1, 0, 16'h0055);
        checkOutput("after_clear_Q", 32'(Q), 32'h0055);

        applyStimulus(0, 1, 1, 0, 16'h0056);
        held_q   = Q;
        held_cnt = 32'(contagem);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 16'h0777);
        checkOutput("hold_contagem", 32'(contagem), 32'd2);
        checkOutput("hold_Q", 32'(Q), 32'h0055);
        checkOutput("hold_vs_before", 32'(Q) ^ held_cnt, 32'(held_q) ^ 32'(contagem));

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 8,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                          WIDTH'($urandom));
        end
        applyStimulus(0, 0, 0, 0, '0);
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
